// File: rtl/game_phase_sequencer.sv
// Game phase sequencer: walks each level through PRELIM, GAME, ANSWER and POST,
// counting seconds down on Tick1Hz, and produces the level-scaled ClkSymGen pulse.
module game_phase_sequencer #(
    parameter int unsigned PRELIM_SEC = 3,
    parameter int unsigned GAME_SEC   = 30,
    parameter int unsigned ANSWER_SEC = 10,
    parameter int unsigned POST_SEC   = 3,
    parameter int unsigned NUM_LEVELS = 4,
    parameter int unsigned TIME_W     = 6,
    parameter int unsigned SYM_BASE   = 100000000,
    parameter int unsigned SYM_STEP   = 5000000,
    parameter int unsigned SYM_MIN    = 10000000
) (
    input  logic              Clk100M,
    input  logic              reset,
    input  logic              Start,
    input  logic              Tick1Hz,
    input  logic              AnswerDone,
    output logic              prelimPeriod,
    output logic              gamePeriod,
    output logic              answerPeriod,
    output logic              postPeriod,
    output logic [2:0]        level,
    output logic [TIME_W-1:0] secLeft,
    output logic              levelChng,
    output logic              ClkSymGen,
    output logic              gameOver
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELIM,
        S_GAME,
        S_ANSWER,
        S_POST,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        level_q, level_d;
    logic [TIME_W-1:0] sec_left_q, sec_left_d;
    logic              level_chng_q, level_chng_d;
    logic              clk_sym_gen_q, clk_sym_gen_d;
    logic              game_over_q, game_over_d;
    logic              prelim_q, prelim_d;
    logic              game_q, game_d;
    logic              answer_q, answer_d;
    logic              post_q, post_d;
    logic [31:0]       sym_max_q, sym_max_d;
    logic [31:0]       sym_cnt_q, sym_cnt_d;

    logic              sec_last;
    logic [2:0]        level_inc;
    logic [31:0]       sym_step;
    logic [31:0]       sym_diff;

    // Next-state, countdown, symbol-rate counter and registered output decode
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        sec_left_d    = sec_left_q;
        level_chng_d  = 1'b0;
        clk_sym_gen_d = 1'b0;
        game_over_d   = game_over_q;
        sym_max_d     = sym_max_q;
        sym_cnt_d     = sym_cnt_q;

        sec_last  = Tick1Hz && (sec_left_q <= TIME_W'(1));
        level_inc = level_q + 3'd1;
        sym_step  = SYM_STEP * {29'd0, level_inc};
        sym_diff  = sym_max_q - sym_step;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d      = S_PRELIM;
                    level_d      = 3'd1;
                    sec_left_d   = TIME_W'(PRELIM_SEC);
                    sym_max_d    = SYM_BASE;
                    game_over_d  = 1'b0;
                    level_chng_d = 1'b1;
                end
            end
            S_PRELIM: begin
                if (sec_last) begin
                    state_d    = S_GAME;
                    sec_left_d = TIME_W'(GAME_SEC);
                    sym_cnt_d  = '0;
                end else if (Tick1Hz) begin
                    sec_left_d = sec_left_q - TIME_W'(1);
                end
            end
            S_GAME: begin
                if (sym_cnt_q == sym_max_q - 32'd1) begin
                    sym_cnt_d     = '0;
                    clk_sym_gen_d = 1'b1;
                end else begin
                    sym_cnt_d = sym_cnt_q + 32'd1;
                end
                // A terminal count on the exit cycle is dropped so the pulse never lands outside GAME
                if (sec_last) begin
                    state_d       = S_ANSWER;
                    sec_left_d    = TIME_W'(ANSWER_SEC);
                    sym_cnt_d     = '0;
                    clk_sym_gen_d = 1'b0;
                end else if (Tick1Hz) begin
                    sec_left_d = sec_left_q - TIME_W'(1);
                end
            end
            S_ANSWER: begin
                if (AnswerDone || sec_last) begin
                    state_d    = S_POST;
                    sec_left_d = TIME_W'(POST_SEC);
                end else if (Tick1Hz) begin
                    sec_left_d = sec_left_q - TIME_W'(1);
                end
            end
            S_POST: begin
                if (sec_last) begin
                    if (level_q == 3'(NUM_LEVELS)) begin
                        state_d     = S_DONE;
                        game_over_d = 1'b1;
                        sec_left_d  = '0;
                    end else begin
                        state_d      = S_PRELIM;
                        level_d      = level_inc;
                        level_chng_d = 1'b1;
                        sec_left_d   = TIME_W'(PRELIM_SEC);
                        if ((sym_step > sym_max_q) || (sym_diff < SYM_MIN))
                            sym_max_d = SYM_MIN;
                        else
                            sym_max_d = sym_diff;
                    end
                end else if (Tick1Hz) begin
                    sec_left_d = sec_left_q - TIME_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        prelim_d = (state_d == S_PRELIM);
        game_d   = (state_d == S_GAME);
        answer_d = (state_d == S_ANSWER);
        post_d   = (state_d == S_POST);
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            state_q       <= S_IDLE;
            level_q       <= '0;
            sec_left_q    <= '0;
            level_chng_q  <= 1'b0;
            clk_sym_gen_q <= 1'b0;
            game_over_q   <= 1'b0;
            prelim_q      <= 1'b0;
            game_q        <= 1'b0;
            answer_q      <= 1'b0;
            post_q        <= 1'b0;
            sym_max_q     <= SYM_BASE;
            sym_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            sec_left_q    <= sec_left_d;
            level_chng_q  <= level_chng_d;
            clk_sym_gen_q <= clk_sym_gen_d;
            game_over_q   <= game_over_d;
            prelim_q      <= prelim_d;
            game_q        <= game_d;
            answer_q      <= answer_d;
            post_q        <= post_d;
            sym_max_q     <= sym_max_d;
            sym_cnt_q     <= sym_cnt_d;
        end
    end

    assign prelimPeriod = prelim_q;
    assign gamePeriod   = game_q;
    assign answerPeriod = answer_q;
    assign postPeriod   = post_q;
    assign level        = level_q;
    assign secLeft      = sec_left_q;
    assign levelChng    = level_chng_q;
    assign ClkSymGen    = clk_sym_gen_q;
    assign gameOver     = game_over_q;

endmodule

// File: doc/game_phase_sequencer.md
Name: game_phase_sequencer

Overview:
Consumes the one-cycle Clk1Hz pulse from the clock divider and sequences one game level through four periods: prelim, game, answer and post. It counts seconds down in each period and advances the level after each post period. It also generates the ClkSymGen symbol-rate pulse, whose period shrinks as the level rises. Its outputs drive the 7-seg countdown and the symbol generator.

Parameters:
PRELIM_SEC, 3, prelim period length in Tick1Hz pulses (1..2^TIME_W-1)
GAME_SEC, 30, game period length in ticks
ANSWER_SEC, 10, answer period length in ticks
POST_SEC, 3, post period length in ticks
NUM_LEVELS, 4, last level (1..7)
TIME_W, 6, width of secLeft
SYM_BASE, 100000000, ClkSymGen period at level 1, in Clk100M cycles
SYM_STEP, 5000000, per-level reduction multiplier
SYM_MIN, 10000000, floor on the ClkSymGen period

Ports:
Clk100M  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
Start  in  1  level-sensitive start request
Tick1Hz  in  1  one-cycle pulse once per second (Clk1Hz)
AnswerDone  in  1  player submitted answer; ends the answer period early
prelimPeriod  out  1  high while in PRELIM
gamePeriod  out  1  high while in GAME
answerPeriod  out  1  high while in ANSWER
postPeriod  out  1  high while in POST
level  out  3  current level; 0 when idle
secLeft  out  TIME_W  seconds remaining in the current period
levelChng  out  1  one-cycle pulse when a level begins
ClkSymGen  out  1  one-cycle symbol-rate pulse, GAME only
gameOver  out  1  high in DONE

Behaviour:
- One clock; reset is synchronous and active-high. Every output and register is registered on Clk100M.
- Reset (takes priority over all inputs, including mid-operation):
  - state = IDLE; all four period flags = 0.
  - level = 0, secLeft = 0, levelChng = 0, ClkSymGen = 0, gameOver = 0.
  - symMax = SYM_BASE, symCnt = 0.
- States are IDLE, PRELIM, GAME, ANSWER, POST and DONE. The period flags are one-hot in timed states and all 0 in IDLE and DONE.
- IDLE, or DONE, with Start = 1: on the next edge enter PRELIM with level = 1, secLeft = PRELIM_SEC, symMax = SYM_BASE, gameOver = 0, levelChng = 1 for one cycle. Start is ignored in the other states.
- Timed states, on a cycle with Tick1Hz = 1:
  - If secLeft > 1: secLeft decrements.
  - If secLeft == 1: move to the next state and load its duration.
  - The order is PRELIM→GAME→ANSWER→POST.
- Tick1Hz is free-running and is not realigned to period entry, so the first second of a period may be partial (0 to 1 s). This is accepted.
- ANSWER with AnswerDone = 1: enter POST on the next edge with secLeft = POST_SEC, regardless of Tick1Hz. AnswerDone together with a final tick gives the same result. AnswerDone outside ANSWER is ignored.
- End of POST:
  - If level == NUM_LEVELS: enter DONE with gameOver = 1, secLeft = 0, level held.
  - Otherwise: enter PRELIM with level += 1, levelChng pulse, and symMax updated.
- symMax update: symMax = symMax − SYM_STEP × (new level), computed at 32-bit unsigned width. If the result underflows or is below SYM_MIN, symMax = SYM_MIN.
- ClkSymGen:
  - symCnt clears on every entry to GAME and counts only in GAME.
  - When symCnt == symMax − 1: ClkSymGen = 1 for one cycle and symCnt resets to 0. The first pulse comes symMax cycles after GAME entry.
  - ClkSymGen = 0 in all other states. A pending count is discarded on GAME exit.
- levelChng is never high for more than one consecutive cycle.

Test Plan:
Small parameters are used throughout: PRELIM=2, GAME=3, ANSWER=3, POST=2, NUM_LEVELS=3, SYM_BASE=20, SYM_STEP=4, SYM_MIN=6; Tick1Hz pulsed every 50 cycles.
- Reset then Start pulse → next edge: prelimPeriod = 1, level = 1, secLeft = 2, levelChng high for exactly 1 cycle. Two ticks later → gamePeriod = 1, secLeft = 3.
- Full level 1 with no AnswerDone → period flags follow PRELIM→GAME→ANSWER→POST. After the second POST tick: level = 2, levelChng pulse, symMax = 12.
- In level-1 GAME → ClkSymGen pulses every 20 cycles, first pulse 20 cycles after entry, no pulses outside GAME. In level 3: symMax = 12 − 12 = 0, clamped to 6, so pulses come every 6 cycles.
- AnswerDone asserted 5 cycles into ANSWER (secLeft = 3) → next edge postPeriod = 1, secLeft = 2. AnswerDone during GAME → no effect.
- End of level-3 POST → gameOver = 1, all period flags 0, secLeft = 0, level = 3. Start → level = 1, symMax = 20, prelimPeriod = 1.
- reset asserted mid-GAME on the same cycle as Tick1Hz and ClkSymGen terminal count → next edge: IDLE with all outputs 0 and no ClkSymGen pulse.
